video_rx_ctrl: RTL and testbench

Sequences the SPI video-capture path in the `CLK_40` domain. It drives `chip_select` toward the external video source and detects rising edges on the already-synchronised SPI clock. It shifts MISO bits into `WORD_W`-bit words and hands each word to the frame buffer over a valid/ready write port, with wrapping addresses. It sits between the `dff_sync2` synchronisers and the frame-buffer writer, and replaces the ad-hoc shift register clocked by a derived clock.

---
 rtl/video_rx_pkg.sv | 7 +
 rtl/rise_detect.sv | 13 +
 rtl/video_rx_ctrl.sv | 135 +++++++++++++
 tb/tb_video_rx_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/video_rx_pkg.sv
// video_rx_pkg: shared state encoding and default sizes for the SPI video receiver
package video_rx_pkg;
  typedef enum logic [1:0] {IDLE, ARM, STREAM, ERROR} rx_state_t;
  localparam int WORD_W_DEF          = 24;
  localparam int WORDS_PER_FRAME_DEF = 4800;
  localparam int TIMEOUT_CYC_DEF     = 40000;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: registered previous-value rising-edge detector (clk, active-low sync rst_n, d in, rise out)
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic prev_q, prev_d;
  assign prev_d = d;
  assign rise   = d & ~prev_q;
  always_ff @(posedge clk)
    prev_q <= !rst_n ? 1'b0 : prev_d;
endmodule

// File: rtl/video_rx_ctrl.sv
// video_rx_ctrl: SPI video capture sequencer; ins CLK_40/reset(n)/init/vid_start/spi_clk_sync/miso_sync/wr_ready, outs chip_select/wr_valid/wr_data/wr_addr/frame_done/frame_count/overflow/busy; VIDEO_RX_TIMEOUT_EN adds STREAM watchdog
module video_rx_ctrl
  import video_rx_pkg::*;
#(
  parameter int WORD_W          = WORD_W_DEF,
  parameter int WORDS_PER_FRAME = WORDS_PER_FRAME_DEF,
  parameter int ADDR_W          = 13,
  parameter int TIMEOUT_CYC     = TIMEOUT_CYC_DEF
) (
  input  logic              CLK_40,
  input  logic              reset,
  input  logic              init,
  input  logic              vid_start,
  input  logic              spi_clk_sync,
  input  logic              miso_sync,
  input  logic              wr_ready,
  output logic              chip_select,
  output logic              wr_valid,
  output logic [WORD_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              overflow,
  output logic              busy
);
  localparam int BIT_W = $clog2(WORD_W);
  if (2 ** ADDR_W < WORDS_PER_FRAME || TIMEOUT_CYC < 1 || WORD_W < 2) begin : g_cfg_err
    $error("video_rx_ctrl: bad parameter set");
  end
  rx_state_t         state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] sr_q, sr_d, wr_data_q, wr_data_d, word;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              wr_valid_q, wr_valid_d, frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d, chip_select_q, chip_select_d;
  logic              spi_rise, xfer, last_bit, last_addr, timeout;
  rise_detect u_spi_rise (
    .clk  (CLK_40),
    .rst_n(reset),
    .d    (spi_clk_sync),
    .rise (spi_rise)
  );
  assign xfer      = wr_valid_q & wr_ready;
  assign last_bit  = bit_cnt_q == BIT_W'(WORD_W - 1);
  assign last_addr = wr_addr_q == ADDR_W'(WORDS_PER_FRAME - 1);
  assign word      = {sr_q[WORD_W-2:0], miso_sync};
`ifdef VIDEO_RX_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  assign wdog_d  = (state_q != STREAM || spi_rise) ? '0 : wdog_q + 1'b1;
  assign timeout = state_q == STREAM && !spi_rise && wdog_q == WDOG_W'(TIMEOUT_CYC - 1);
  always_ff @(posedge CLK_40)
    wdog_q <= !reset ? '0 : wdog_d;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    sr_d          = sr_q;
    wr_data_d     = wr_data_q;
    wr_valid_d    = wr_valid_q & ~xfer;
    wr_addr_d     = xfer ? (last_addr ? '0 : wr_addr_q + 1'b1) : wr_addr_q;
    frame_done_d  = xfer & last_addr;
    frame_count_d = frame_count_q + {15'd0, xfer & last_addr};
    overflow_d    = overflow_q;
    case (state_q)
      IDLE: state_d = init ? ARM : IDLE;
      ARM: begin
        bit_cnt_d  = '0;
        sr_d       = '0;
        wr_addr_d  = '0;
        wr_valid_d = 1'b0;
        state_d    = vid_start ? STREAM : ARM;
      end
      STREAM: begin
        if (timeout) begin
          // pending word is left to finish its handshake from ERROR
          state_d   = ERROR;
          bit_cnt_d = '0;
        end else if (spi_rise) begin
          sr_d      = word;
          bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
          if (last_bit && wr_valid_q && !wr_ready) overflow_d = 1'b1;
          else if (last_bit) begin
            wr_valid_d = 1'b1;
            wr_data_d  = word;
          end
        end
      end
      default: state_d = ERROR;
    endcase
    if (init && (state_q == STREAM || state_q == ERROR)) begin
      state_d    = ARM;
      bit_cnt_d  = '0;
      wr_valid_d = 1'b0;
      wr_addr_d  = '0;
    end
    chip_select_d = state_d == IDLE || state_d == ERROR;
  end
  always_ff @(posedge CLK_40) begin
    if (!reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      sr_q          <= '0;
      wr_data_q     <= '0;
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
      chip_select_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      sr_q          <= sr_d;
      wr_data_q     <= wr_data_d;
      wr_valid_q    <= wr_valid_d;
      wr_addr_q     <= wr_addr_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      overflow_q    <= overflow_d;
      chip_select_q <= chip_select_d;
    end
  end
  assign chip_select = chip_select_q;
  assign wr_valid    = wr_valid_q;
  assign wr_data     = wr_data_q;
  assign wr_addr     = wr_addr_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign overflow    = overflow_q;
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_video_rx_ctrl.sv
// tb_video_rx_ctrl: directed self-checking bench for video_rx_ctrl
module tb_video_rx_ctrl;
  logic        clk = 1'b0, reset = 1'b0, init = 1'b0, vid_start = 1'b0;
  logic        spi_clk = 1'b0, miso = 1'b0, wr_ready = 1'b0;
  logic        chip_select, wr_valid, frame_done, overflow, busy;
  logic [23:0] wr_data;
  logic [12:0] wr_addr;
  logic [15:0] frame_count;
  int          n_checks = 0, n_fail = 0, n_xfer = 0, n_fd = 0, n_valid = 0;
  logic [23:0] xd[$];
  logic [12:0] xa[$];
  video_rx_ctrl #(
    .WORD_W(24), .WORDS_PER_FRAME(4), .ADDR_W(13), .TIMEOUT_CYC(40000)
  ) dut (
    .CLK_40(clk), .reset(reset), .init(init), .vid_start(vid_start),
    .spi_clk_sync(spi_clk), .miso_sync(miso), .wr_ready(wr_ready),
    .chip_select(chip_select), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_addr(wr_addr), .frame_done(frame_done), .frame_count(frame_count),
    .overflow(overflow), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (wr_valid && wr_ready) begin
      n_xfer++;
      xd.push_back(wr_data);
      xa.push_back(wr_addr);
    end
    if (frame_done) n_fd++;
    if (wr_valid) n_valid++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    miso = b;
    spi_clk = 1'b0;
    step(4);
    spi_clk = 1'b1;
    step(4);
  endtask
  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[23-i]);
  endtask
  task automatic arm_and_start();
    init = 1'b1;
    step(1);
    init = 1'b0;
    vid_start = 1'b1;
    step(1);
    vid_start = 1'b0;
  endtask
  initial begin
    step(3);
    check("rst_cs", chip_select, 1);
    check("rst_valid", wr_valid, 0);
    check("rst_data", wr_data, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_fd", frame_done, 0);
    check("rst_fc", frame_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    step(1);
    init = 1'b1;
    step(1);
    check("arm_cs", chip_select, 0);
    check("arm_busy", busy, 1);
    init = 1'b0;
    vid_start = 1'b1;
    step(1);
    vid_start = 1'b0;
    wr_ready = 1'b1;
    send_bits(24'hA5C33C, 24);
    check("nom_n", n_xfer, 1);
    check("nom_vcyc", n_valid, 1);
    check("nom_data", xd[0], 24'hA5C33C);
    check("nom_addr", xa[0], 0);
    check("nom_next", wr_addr, 1);
    send_bits(24'h000001, 24);
    send_bits(24'h800000, 24);
    send_bits(24'hFFFFFF, 24);
    check("frm_n", n_xfer, 4);
    check("frm_a1", xa[1], 1);
    check("frm_a2", xa[2], 2);
    check("frm_a3", xa[3], 3);
    check("frm_d3", xd[3], 24'hFFFFFF);
    check("frm_wrap", wr_addr, 0);
    check("frm_fd", n_fd, 1);
    check("frm_fc", frame_count, 1);
    wr_ready = 1'b0;
    send_bits(24'h0F0F0F, 24);
    check("sim_pend", wr_valid, 1);
    send_bits(24'hF0F0F0, 23);
    miso = 1'b0;
    spi_clk = 1'b0;
    step(4);
    spi_clk = 1'b1;
    wr_ready = 1'b1;
    step(4);
    check("sim_n", n_xfer, 6);
    check("sim_d0", xd[4], 24'h0F0F0F);
    check("sim_a0", xa[4], 0);
    check("sim_d1", xd[5], 24'hF0F0F0);
    check("sim_a1", xa[5], 1);
    check("sim_ovf", overflow, 0);
    send_bits(24'hFFFFFF, 10);
    init = 1'b1;
    step(1);
    check("ri_busy", busy, 1);
    check("ri_addr", wr_addr, 0);
    check("ri_valid", wr_valid, 0);
    init = 1'b0;
    vid_start = 1'b1;
    step(1);
    vid_start = 1'b0;
    wr_ready = 1'b0;
    send_bits(24'h123456, 24);
    send_bits(24'h654321, 24);
    check("bp_valid", wr_valid, 1);
    check("bp_data", wr_data, 24'h123456);
    check("bp_addr", wr_addr, 0);
    check("bp_ovf", overflow, 1);
    check("bp_n", n_xfer, 6);
    wr_ready = 1'b1;
    step(1);
    check("bp_xn", n_xfer, 7);
    check("bp_xd", xd[6], 24'h123456);
    check("bp_xa", wr_addr, 1);
    check("bp_drop", wr_valid, 0);
`ifdef VIDEO_RX_TIMEOUT_EN
    for (int i = 0; i < 40100 && !chip_select; i++) step(1);
    check("to_cs", chip_select, 1);
    check("to_busy", busy, 1);
    arm_and_start();
    check("to_rearm_cs", chip_select, 0);
    check("to_rearm_addr", wr_addr, 0);
`else
    step(40100);
    check("nto_cs", chip_select, 0);
    check("nto_busy", busy, 1);
`endif
    send_bits(24'h5A5A5A, 24);
    check("post_n", n_xfer, 8);
    check("post_d", xd[7], 24'h5A5A5A);
    wr_ready = 1'b0;
    send_bits(24'h777777, 24);
    check("mid_pend", wr_valid, 1);
    reset = 1'b0;
    step(1);
    check("mid_valid", wr_valid, 0);
    check("mid_data", wr_data, 0);
    check("mid_addr", wr_addr, 0);
    check("mid_fc", frame_count, 0);
    check("mid_ovf", overflow, 0);
    check("mid_cs", chip_select, 1);
    check("mid_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
